// File: rtl/fpu_req_issuer_if.sv
// fpu_req_issuer_if: issue, response, flush and busy signals between the
// FP request issuer (master) and the FP unit (slave).
interface fpu_req_issuer_if #(
    parameter int WIDTH        = 64,
    parameter int NUM_OPERANDS = 3,
    parameter int NUM_TAGS     = 4
);
    localparam int TAG_W = $clog2(NUM_TAGS);

    // issue payload and handshake
    logic [NUM_OPERANDS*WIDTH-1:0] operands;
    logic [2:0]                    rnd_mode;
    logic [3:0]                    op;
    logic                          op_mod;
    logic [2:0]                    src_fmt;
    logic [2:0]                    dst_fmt;
    logic [1:0]                    int_fmt;
    logic                          vectorial;
    logic [TAG_W-1:0]              in_tag;
    logic                          in_valid;
    logic                          in_ready;

    // response
    logic [WIDTH-1:0]              result;
    logic [4:0]                    status;
    logic [TAG_W-1:0]              out_tag;
    logic                          out_valid;
    logic                          out_ready;

    // control
    logic                          flush;
    logic                          busy;

    modport master (
        output operands, rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt, vectorial,
        output in_tag, in_valid, out_ready, flush,
        input  in_ready, result, status, out_tag, out_valid, busy
    );

    modport slave (
        input  operands, rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt, vectorial,
        input  in_tag, in_valid, out_ready, flush,
        output in_ready, result, status, out_tag, out_valid, busy
    );
endinterface

// File: rtl/fpu_req_issuer.sv
// fpu_req_issuer: in-order issue of core FP ops to the FPU with tags from a
// small reorder buffer; out-of-order results are retired in program order.
// Optional macro FPU_ISSUER_FFLAGS_ACC_EN adds a sticky fflags accumulator
// (fflags_clr_i / fflags_o).
module fpu_req_issuer #(
    parameter int WIDTH        = 64,
    parameter int NUM_OPERANDS = 3,
    parameter int NUM_TAGS     = 4,
    parameter int RD_W         = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    // core request
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [NUM_OPERANDS*WIDTH-1:0] req_operands_i,
    input  logic [2:0]                    req_rnd_mode_i,
    input  logic [3:0]                    req_op_i,
    input  logic                          req_op_mod_i,
    input  logic [2:0]                    req_src_fmt_i,
    input  logic [2:0]                    req_dst_fmt_i,
    input  logic [1:0]                    req_int_fmt_i,
    input  logic                          req_vectorial_i,
    input  logic [RD_W-1:0]               req_rd_i,

    // FPU side
    fpu_req_issuer_if.master              fpu,

    input  logic                          flush_i,

    // register writeback
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [RD_W-1:0]               wb_rd_o,
    output logic [WIDTH-1:0]              wb_result_o,
    output logic [4:0]                    wb_status_o,
`ifdef FPU_ISSUER_FFLAGS_ACC_EN
    input  logic                          fflags_clr_i,
    output logic [4:0]                    fflags_o,
`endif
    output logic                          busy_o
);
    localparam int TAG_W = $clog2(NUM_TAGS);

    typedef enum logic [1:0] {
        E_FREE   = 2'd0,
        E_ISSUED = 2'd1,
        E_DONE   = 2'd2
    } ent_e;

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_PEND = 1'b1
    } iss_e;

    typedef struct packed {
        logic [NUM_OPERANDS*WIDTH-1:0] operands;
        logic [2:0]                    rnd_mode;
        logic [3:0]                    op;
        logic                          op_mod;
        logic [2:0]                    src_fmt;
        logic [2:0]                    dst_fmt;
        logic [1:0]                    int_fmt;
        logic                          vectorial;
    } payload_t;

    // ROB state and per-entry data
    ent_e             ent_st_q  [NUM_TAGS];
    ent_e             ent_st_d  [NUM_TAGS];
    logic [RD_W-1:0]  ent_rd_q  [NUM_TAGS];
    logic [RD_W-1:0]  ent_rd_d  [NUM_TAGS];
    logic [WIDTH-1:0] ent_res_q [NUM_TAGS];
    logic [WIDTH-1:0] ent_res_d [NUM_TAGS];
    logic [4:0]       ent_sts_q [NUM_TAGS];
    logic [4:0]       ent_sts_d [NUM_TAGS];
    logic [TAG_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [TAG_W-1:0] head_ptr_q,  head_ptr_d;

    // issue register
    iss_e             iss_q, iss_d;
    payload_t         pl_q,  pl_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // handshake qualifiers
    logic issue_take;
    logic accept;
    logic capture;
    logic retire;
    logic rob_any;

    // Handshake decode; ready signals are gated by reset and flush so nothing
    // is accepted in a cycle whose state is about to be discarded.
    always_comb begin
        issue_take  = (iss_q == ISS_PEND) && fpu.in_ready;
        req_ready_o = !rst_i && !flush_i && (ent_st_q[alloc_ptr_q] == E_FREE) &&
                      ((iss_q == ISS_IDLE) || fpu.in_ready);
        accept      = req_valid_i && req_ready_o;
        capture     = fpu.out_valid && !rst_i && !flush_i &&
                      (ent_st_q[fpu.out_tag] == E_ISSUED);
        wb_valid_o  = (ent_st_q[head_ptr_q] == E_DONE);
        retire      = wb_valid_o && wb_ready_i && !flush_i;
    end

    // Issue register next state: latch on accept, drop on take unless refilled.
    always_comb begin
        iss_d = iss_q;
        pl_d  = pl_q;
        tag_d = tag_q;
        case (iss_q)
            ISS_IDLE: if (accept) iss_d = ISS_PEND;
            ISS_PEND: if (issue_take && !accept) iss_d = ISS_IDLE;
            default:  iss_d = ISS_IDLE;
        endcase
        if (accept) begin
            pl_d.operands  = req_operands_i;
            pl_d.rnd_mode  = req_rnd_mode_i;
            pl_d.op        = req_op_i;
            pl_d.op_mod    = req_op_mod_i;
            pl_d.src_fmt   = req_src_fmt_i;
            pl_d.dst_fmt   = req_dst_fmt_i;
            pl_d.int_fmt   = req_int_fmt_i;
            pl_d.vectorial = req_vectorial_i;
            tag_d          = alloc_ptr_q;
        end
        if (flush_i) iss_d = ISS_IDLE;
    end

    // Issue register flops; payload and tag are cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iss_q <= ISS_IDLE;
            pl_q  <= '0;
            tag_q <= '0;
        end else begin
            iss_q <= iss_d;
            pl_q  <= pl_d;
            tag_q <= tag_d;
        end
    end

    // ROB next state. Accept targets a FREE entry, capture an ISSUED one and
    // retire the DONE head, so the three never collide on the same entry.
    always_comb begin
        ent_st_d    = ent_st_q;
        ent_rd_d    = ent_rd_q;
        ent_res_d   = ent_res_q;
        ent_sts_d   = ent_sts_q;
        alloc_ptr_d = alloc_ptr_q;
        head_ptr_d  = head_ptr_q;
        if (accept) begin
            ent_st_d[alloc_ptr_q] = E_ISSUED;
            ent_rd_d[alloc_ptr_q] = req_rd_i;
            alloc_ptr_d           = alloc_ptr_q + TAG_W'(1);
        end
        if (capture) begin
            ent_st_d[fpu.out_tag]  = E_DONE;
            ent_res_d[fpu.out_tag] = fpu.result;
            ent_sts_d[fpu.out_tag] = fpu.status;
        end
        if (retire) begin
            ent_st_d[head_ptr_q] = E_FREE;
            head_ptr_d           = head_ptr_q + TAG_W'(1);
        end
        if (flush_i) begin
            for (int i = 0; i < NUM_TAGS; i++) ent_st_d[i] = E_FREE;
            alloc_ptr_d = '0;
            head_ptr_d  = '0;
        end
    end

    // ROB control flops: entry states and pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_TAGS; i++) ent_st_q[i] <= E_FREE;
            alloc_ptr_q <= '0;
            head_ptr_q  <= '0;
        end else begin
            ent_st_q    <= ent_st_d;
            alloc_ptr_q <= alloc_ptr_d;
            head_ptr_q  <= head_ptr_d;
        end
    end

    // ROB data flops; contents only matter while the entry is not FREE.
    always_ff @(posedge clk_i) begin
        ent_rd_q  <= ent_rd_d;
        ent_res_q <= ent_res_d;
        ent_sts_q <= ent_sts_d;
    end

    // Occupancy for busy reporting.
    always_comb begin
        rob_any = 1'b0;
        for (int i = 0; i < NUM_TAGS; i++)
            if (ent_st_q[i] != E_FREE) rob_any = 1'b1;
    end

`ifdef FPU_ISSUER_FFLAGS_ACC_EN
    logic [4:0] fflags_q, fflags_d;

    // Sticky status accumulation; a retire in the clear cycle survives it.
    always_comb begin
        fflags_d = fflags_clr_i ? 5'd0 : fflags_q;
        if (retire) fflags_d = fflags_d | wb_status_o;
    end

    // Accumulator flop; flush leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) fflags_q <= '0;
        else       fflags_q <= fflags_d;
    end

    assign fflags_o = fflags_q;
`endif

    // FPU-side outputs
    assign fpu.in_valid  = (iss_q == ISS_PEND);
    assign fpu.in_tag    = tag_q;
    assign fpu.operands  = pl_q.operands;
    assign fpu.rnd_mode  = pl_q.rnd_mode;
    assign fpu.op        = pl_q.op;
    assign fpu.op_mod    = pl_q.op_mod;
    assign fpu.src_fmt   = pl_q.src_fmt;
    assign fpu.dst_fmt   = pl_q.dst_fmt;
    assign fpu.int_fmt   = pl_q.int_fmt;
    assign fpu.vectorial = pl_q.vectorial;
    assign fpu.out_ready = !rst_i && !flush_i;
    assign fpu.flush     = flush_i;

    // writeback payload from the head entry
    assign wb_rd_o     = ent_rd_q[head_ptr_q];
    assign wb_result_o = ent_res_q[head_ptr_q];
    assign wb_status_o = ent_sts_q[head_ptr_q];

    assign busy_o = rob_any || (iss_q == ISS_PEND) || fpu.busy;
endmodule

// File: doc/fpu_req_issuer.md
Name: fpu_req_issuer

Overview:
- Core-side initiator for the FP unit's valid/ready request/response interface.
- Accepts decoded FP operations from the core and issues them to the FPU in order, each carrying a tag allocated from a small reorder buffer.
- Collects FPU results, which may return out of order across op groups, and retires them to the register writeback port in program order.
- Owns FPU flush and busy tracking.

Parameters:
- WIDTH, 64, operand/result width in bits.
- NUM_OPERANDS, 3, operands per operation.
- NUM_TAGS, 4, reorder-buffer entries. Must be a power of 2 and ≥2. TAG_W = $clog2(NUM_TAGS).
- RD_W, 5, destination register index width.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous, active-high reset.
- req_valid_i in 1: core request valid.
- req_ready_o out 1: request accepted when req_valid_i && req_ready_o.
- req_operands_i in NUM_OPERANDS*WIDTH: source operands.
- req_rnd_mode_i in 3, req_op_i in 4, req_op_mod_i in 1, req_src_fmt_i in 3, req_dst_fmt_i in 3, req_int_fmt_i in 2, req_vectorial_i in 1: operation fields.
- req_rd_i in RD_W: destination register.
- fpu_operands_o out NUM_OPERANDS*WIDTH; fpu_rnd_mode_o, fpu_op_o, fpu_op_mod_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o, fpu_vectorial_o out (widths as above): registered issue payload.
- fpu_tag_o out TAG_W: tag of the issued op.
- fpu_in_valid_o out 1, fpu_in_ready_i in 1: issue handshake.
- fpu_result_i in WIDTH, fpu_status_i in 5 {NV,DZ,OF,UF,NX}, fpu_tag_i in TAG_W, fpu_out_valid_i in 1: FPU response.
- fpu_out_ready_o out 1: response ready.
- flush_i in 1: kill all in-flight work.
- fpu_flush_o out 1: flush to FPU.
- fpu_busy_i in 1: FPU busy. Informational only; OR'd into busy_o.
- wb_valid_o out 1, wb_ready_i in 1: writeback handshake.
- wb_rd_o out RD_W, wb_result_o out WIDTH, wb_status_o out 5: writeback payload.
- busy_o out 1: any entry not FREE, issue register full, or fpu_busy_i.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - All ROB entries FREE; alloc_ptr = head_ptr = 0; issue register empty.
  - Registered outputs cleared: fpu_in_valid_o=0, wb_valid_o=0, fpu_tag_o=0, payload=0.
  - While rst_i=1, req_ready_o=0 and fpu_out_ready_o=0 (combinationally gated).
  - Reset mid-operation discards everything without asserting fpu_flush_o.
- ROB entry state: FREE -> ISSUED (on request acceptance) -> DONE (on result capture) -> FREE (on retire or flush). Each entry stores rd, result, status.
- Issue register FSM, two states:
  - IDLE -> PEND on request acceptance. Payload and tag are latched; fpu_in_valid_o=1 from the next cycle.
  - PEND -> IDLE on fpu_in_valid_o && fpu_in_ready_i.
  - PEND -> PEND when a new request is accepted in the same cycle the current one is taken (back-to-back: one issue per cycle).
  - While PEND and not taken, fpu_in_valid_o and every fpu_* payload bit stay stable; valid is never withdrawn. The FPU ready may depend on valid; there is no combinational path from fpu_in_ready_i to fpu_in_valid_o.
- req_ready_o = !rst_i && !flush_i && entry[alloc_ptr]==FREE && (issue register IDLE || fpu_in_ready_i).
- On acceptance: entry[alloc_ptr] becomes ISSUED with rd; tag = alloc_ptr; alloc_ptr increments mod NUM_TAGS (wrap-around).
- Latency:
  - Request accepted at cycle N -> fpu_in_valid_o at N+1.
  - FPU response at cycle M -> entry DONE at M+1 -> wb_valid_o at M+1 if it is the head.
  - No bypass; minimum request-to-writeback = FPU latency + 2.
- fpu_out_ready_o = !rst_i && !flush_i. Every entry is pre-reserved, so responses are never backpressured.
- A response whose tag indexes a non-ISSUED entry (stale after flush) is accepted and dropped; no state change.
- wb_valid_o = entry[head_ptr]==DONE (registered state). On wb_valid_o && wb_ready_i the entry becomes FREE and head_ptr increments mod NUM_TAGS.
- A freed entry is reusable from the next cycle: a full ROB raises req_ready_o one cycle after retire.
- Simultaneous events:
  - Capture to entry X and retire of head Y≠X in the same cycle are both performed.
  - Capture cannot target the head being retired: a head that is retiring is already DONE.
- Flush:
  - fpu_flush_o = flush_i (combinational, same cycle).
  - Next edge: all entries FREE, pointers reset to 0, issue register IDLE, wb_valid_o=0.
  - A request presented during flush is not accepted.
  - Flush during a wb handshake cycle: that retire is cancelled.

Optional Feature:
- FPU_ISSUER_FFLAGS_ACC_EN defined: adds input fflags_clr_i (1) and output fflags_o (5).
  - fflags_o is a sticky OR of wb_status_o over every retire handshake; reset value 0.
  - fflags_clr_i clears it next cycle; a retire in the same cycle wins, so the new flags are kept.
  - Flush does not clear fflags_o.
- Undefined: no such ports, no accumulator logic.

Test Plan:
- Reset, one request rd=5, fpu_in_ready_i=1; FPU returns tag 0, result 0x4008000000000000, status 0 after 3 cycles -> wb_valid_o=1 with rd 5, that result, status 0, exactly once; busy_o=0 afterward.
- Hold fpu_in_ready_i=0 for 4 cycles with 2 requests queued -> fpu_in_valid_o held at 1, payload and tag 0 unchanged, req_ready_o=0 after the first acceptance; on ready, tag 0 issues, then tag 1 the next cycle.
- Issue tags 0,1,2 (rd 1,2,3); responses return in tag order 2,0,1 -> writebacks strictly rd 1,2,3 with matching results; no writeback before tag 0 returns.
- 4 outstanding with no responses -> req_ready_o=0; return tag 0 and retire -> req_ready_o=1 the following cycle; the next request gets tag 0 (wrap).
- 3 outstanding plus pending issue, assert flush_i 1 cycle -> fpu_flush_o=1 same cycle; next cycle fpu_in_valid_o=0, wb_valid_o=0, busy_o=0 (fpu_busy_i=0); a late response with tag 1 is dropped; the next request gets tag 0.
- (FPU_ISSUER_FFLAGS_ACC_EN) Retire tag 0 status 0x10, tag 1 status 0x04 -> fflags_o=0x14; pulse fflags_clr_i -> 0x00 next cycle.
